// File: rtl/prog_tick_divider.sv
// Programmable multi-channel tick divider: each channel emits a one-cycle tick every act+1
// enabled cycles plus a half-rate square wave, with shadowed divisor updates.
module prog_tick_divider #(
    parameter int W       = 16,
    parameter int NCH     = 2,
    parameter int RST_DIV = 3,
    parameter int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           sclr,
    input  logic [NCH-1:0] en,
    input  logic           wr_en,
    input  logic [CHW-1:0] wr_ch,
    input  logic [W-1:0]   wr_div,
    output logic           wr_ack,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] sq,
    output logic [NCH-1:0] pend
);

    localparam logic [W-1:0] RST_VAL = W'(RST_DIV);

    logic [NCH-1:0][W-1:0] act_q, act_d;
    logic [NCH-1:0][W-1:0] sh_q, sh_d;
    logic [NCH-1:0][W-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]        pend_q, pend_d;
    logic [NCH-1:0]        tick_q, tick_d;
    logic [NCH-1:0]        sq_q, sq_d;
    logic                  wr_ack_q, wr_ack_d;
    logic [NCH-1:0]        wr_hit;

    always_comb begin
        act_d  = act_q;
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        pend_d = pend_q;
        tick_d = '0;
        sq_d   = sq_q;
        wr_hit = '0;
        for (int i = 0; i < NCH; i++) begin
            // Out-of-range channel indices never match, so such writes fall through untouched.
            wr_hit[i] = wr_en && (wr_ch == CHW'(i));
            if (sclr) begin
                cnt_d[i] = '0;
                sq_d[i]  = 1'b0;
                if (wr_hit[i]) begin
                    sh_d[i]   = wr_div;
                    pend_d[i] = 1'b1;
                end
            end else if (en[i]) begin
                if (cnt_q[i] >= act_q[i]) begin
                    cnt_d[i]  = '0;
                    tick_d[i] = 1'b1;
                    sq_d[i]   = ~sq_q[i];
                    // Period boundary: a divisor arriving now or waiting in the shadow takes effect.
                    if (wr_hit[i]) begin
                        act_d[i]  = wr_div;
                        sh_d[i]   = wr_div;
                        pend_d[i] = 1'b0;
                    end else if (pend_q[i]) begin
                        act_d[i]  = sh_q[i];
                        pend_d[i] = 1'b0;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + W'(1);
                    if (wr_hit[i]) begin
                        sh_d[i]   = wr_div;
                        pend_d[i] = 1'b1;
                    end
                end
            end else if (pend_q[i]) begin
                // Idle channel with a waiting divisor: apply it and restart the count so cnt <= act holds.
                cnt_d[i]  = '0;
                pend_d[i] = 1'b0;
                if (wr_hit[i]) begin
                    act_d[i] = wr_div;
                    sh_d[i]  = wr_div;
                end else begin
                    act_d[i] = sh_q[i];
                end
            end else if (wr_hit[i]) begin
                sh_d[i]   = wr_div;
                pend_d[i] = 1'b1;
            end
        end
        wr_ack_d = |wr_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                act_q[i] <= RST_VAL;
                sh_q[i]  <= RST_VAL;
                cnt_q[i] <= '0;
            end
            pend_q   <= '0;
            tick_q   <= '0;
            sq_q     <= '0;
            wr_ack_q <= 1'b0;
        end else begin
            act_q    <= act_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            tick_q   <= tick_d;
            sq_q     <= sq_d;
            wr_ack_q <= wr_ack_d;
        end
    end

    assign tick   = tick_q;
    assign sq     = sq_q;
    assign pend   = pend_q;
    assign wr_ack = wr_ack_q;

endmodule

// File: doc/prog_tick_divider.md
PROG_TICK_DIVIDER -- requirements
Module: prog_tick_divider

Interface
REQ-001 Parameter W, default 16: counter and divisor width in bits, minimum 2.
REQ-002 Parameter NCH, default 2: number of independent divider channels, minimum 1.
REQ-003 Parameter RST_DIV, default 3: divisor value loaded into every channel on reset, less than 2^W.
REQ-004 Parameter CHW, default max(1,clog2(NCH)): width of the channel-select field.
REQ-005 clk  in  1  rising-edge clock for all logic.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 sclr  in  1  synchronous clear of the counting state of all channels.
REQ-008 en  in  NCH  per-channel count enable.
REQ-009 wr_en  in  1  divisor write strobe, valid for one clk cycle.
REQ-010 wr_ch  in  CHW  target channel index for the write.
REQ-011 wr_div  in  W  new divisor value for the target channel.
REQ-012 wr_ack  out  1  one-cycle pulse confirming an accepted write.
REQ-013 tick  out  NCH  one-cycle pulse per completed divide period, per channel.
REQ-014 sq  out  NCH  square wave per channel that toggles on each tick.
REQ-015 pend  out  NCH  high while a written divisor awaits application.

Function
REQ-016 Each channel shall hold an active divisor act, a shadow sh, a pend flag and a counter cnt, all W bits except pend.
REQ-017 When en[i]=1 and cnt<act, the channel shall set cnt to cnt+1 and drive tick[i] low next cycle.
REQ-018 When en[i]=1 and cnt==act (terminal), the channel shall clear cnt, pulse tick[i] for one cycle, and toggle sq[i], all registered on the same edge.
REQ-019 The tick period shall be act+1 cycles and the sq period 2*(act+1); act=0 shall yield a tick every cycle and sq toggling every cycle.
REQ-020 At terminal with pend=1, the channel shall set act to sh and clear pend, so the new divisor governs the following period.
REQ-021 When en[i]=0, the channel shall hold cnt and sq, drive tick[i] low and, if pend=1, set act to sh, clear cnt and clear pend.
REQ-022 A write with wr_en=1 and wr_ch<NCH shall set sh to wr_div and pend to 1, and shall pulse wr_ack on the next cycle.
REQ-023 A write with wr_ch>=NCH shall be ignored: no state change and wr_ack stays 0.
REQ-024 When a write coincides with its channel's terminal or its disabled-pending cycle, wr_div shall load directly into act and pend shall end at 0; wr_ack still pulses.
REQ-025 Back-to-back writes to one channel shall overwrite sh, with the last write winning, and pend shall stay high.
REQ-026 sclr=1 shall clear cnt, tick and sq of all channels and shall preserve act, sh and pend.
REQ-027 sclr shall take priority over counting, while a write arriving in the same cycle shall still be accepted.
REQ-028 cnt shall never exceed act, including right after act is reloaded with a smaller value.
REQ-029 All outputs shall be registered with no combinational path from inputs.

Reset
REQ-030 rst=1 shall immediately set cnt=0, act=sh=RST_DIV, pend=0, tick=0, sq=0 and wr_ack=0, without waiting for clk.
REQ-031 Asserting rst mid-period shall discard any pending divisor, and counting shall restart from 0 on the first edge after release.

Verification (W=8, NCH=3, RST_DIV=3)
REQ-032 Release rst, en=001 -> tick[0] on the 4th edge, then every 4 cycles; sq[0] period 8; tick[1] and tick[2] stay 0.
REQ-033 Write ch0 div=0 at cnt=1 -> pend[0]=1 and wr_ack pulses; the period completes at cnt=3, then tick[0] fires every cycle and pend[0] clears.
REQ-034 Write ch0 div=5 in the terminal cycle -> pend[0] stays 0 and the next tick arrives 6 cycles later.
REQ-035 en[1]=0 with a pending div=7 -> act=7 and cnt=0 after one edge; on setting en[1]=1, the first tick arrives on the 8th edge.
REQ-036 wr_ch=3 with wr_en=1 -> no wr_ack and no pend change; sclr mid-period -> tick=0, sq=0, cnt=0 while act is kept.
REQ-037 Assert rst between clock edges mid-period -> all outputs go to 0 before the next edge.
